// File: rtl/multi_alarm_time_controller.sv
// Time/alarm entry controller: buffers BCD keypad digits, range-checks them and commits
// them to the time-of-day load port or to one of N_ALARMS alarm slots with ring detection.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | display mode; TOGGLE and ESC act on alarms, waits for edit mode
// EDIT_CLK | collecting digits for a new time of day
// EDIT_ALM | collecting digits for the slot latched on entry
module multi_alarm_time_controller #(
   parameter int N_ALARMS       = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              mode,
   input  logic [IDX_W-1:0]        alarm_sel,
   input  logic                    key_valid,
   input  logic [1:0]              key_code,
   input  logic                    digit_valid,
   input  logic [3:0]              digit,
   input  logic [23:0]             hhmmss,
   output logic [23:0]             edit_buf,
   output logic [2:0]              digit_cnt,
   output logic [23:0]             new_time_hhmmss,
   output logic                    ld_timeofdayreg,
   output logic [24*N_ALARMS-1:0]  alarm_times,
   output logic [N_ALARMS-1:0]     alarm_en,
   output logic [N_ALARMS-1:0]     alarm_ring,
   output logic                    clrBuffer,
   output logic                    entry_err
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0] N_SLOTS = (IDX_W+1)'(N_ALARMS);

   localparam logic [1:0] KEY_ENTER  = 2'b01;
   localparam logic [1:0] KEY_ESC    = 2'b10;
   localparam logic [1:0] KEY_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EDIT_CLK = 2'd1,
      EDIT_ALM = 2'd2
   } state_t;

   state_t                     state;
   logic [TMR_W-1:0]           timer;
   logic [IDX_W-1:0]           sel_q;
   logic [23:0]                prev_time;
   logic                       lockout;
   logic [1:0]                 lock_mode;
   logic [N_ALARMS-1:0][23:0]  alm_slot;

   logic                       mode_clk;
   logic                       mode_alm;
   logic                       mode_match;
   logic                       sel_ok;
   logic                       entry_ok;
   logic                       digit_ok;
   logic                       dismiss;
   logic [N_ALARMS-1:0]        commit_slot;
   logic [N_ALARMS-1:0]        toggle_slot;
   logic [N_ALARMS-1:0]        ring_hit;

   assign mode_clk   = (mode == 2'b01);
   assign mode_alm   = (mode == 2'b10);
   assign mode_match = (state == EDIT_CLK) ? mode_clk : ((state == EDIT_ALM) && mode_alm);
   assign sel_ok     = ({1'b0, alarm_sel} < N_SLOTS);
   assign digit_ok   = (digit <= 4'd9) && (digit_cnt < 3'd6);
   // Packed BCD compares like binary because every nibble is already 0..9.
   assign entry_ok   = (digit_cnt == 3'd6) && (edit_buf[23:16] <= 8'h23) &&
                       (edit_buf[15:8] <= 8'h59) && (edit_buf[7:0] <= 8'h59);
   assign alarm_times = alm_slot;

   always_comb begin
      commit_slot = '0;
      toggle_slot = '0;
      dismiss     = 1'b0;
      if ((state == EDIT_ALM) && mode_alm && key_valid && (key_code == KEY_ENTER) && entry_ok)
         commit_slot[sel_q] = 1'b1;
      if (((state == IDLE) || ((state == EDIT_ALM) && mode_alm)) && key_valid &&
          (key_code == KEY_TOGGLE) && sel_ok)
         toggle_slot[alarm_sel] = 1'b1;
      if ((state == IDLE) && key_valid && (key_code == KEY_ESC))
         dismiss = 1'b1;
   end

   always_comb begin
      ring_hit = '0;
      for (int i = 0; i < N_ALARMS; i++)
         ring_hit[i] = alarm_en[i] && (hhmmss == alm_slot[i]) && (hhmmss != prev_time);
   end

   // Alarm bank: a commit beats a same-cycle ring, a disable clears and beats a ring.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alm_slot   <= '0;
         alarm_en   <= '0;
         alarm_ring <= '0;
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            if (commit_slot[i]) begin
               alm_slot[i] <= edit_buf;
               alarm_en[i] <= 1'b1;
            end else if (toggle_slot[i]) begin
               alarm_en[i] <= ~alarm_en[i];
            end
            if (dismiss || (toggle_slot[i] && alarm_en[i]))
               alarm_ring[i] <= 1'b0;
            else if (ring_hit[i] && !commit_slot[i])
               alarm_ring[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         timer           <= '0;
         sel_q           <= '0;
         prev_time       <= '0;
         lockout         <= 1'b0;
         lock_mode       <= 2'b00;
         edit_buf        <= '0;
         digit_cnt       <= '0;
         new_time_hhmmss <= '0;
         ld_timeofdayreg <= 1'b0;
         clrBuffer       <= 1'b0;
         entry_err       <= 1'b0;
      end else begin
         ld_timeofdayreg <= 1'b0;
         clrBuffer       <= 1'b0;
         entry_err       <= 1'b0;
         prev_time       <= hhmmss;
         case (state)
            IDLE: begin
               if (lockout && (mode != lock_mode))
                  lockout <= 1'b0;
               if (key_valid && (key_code == KEY_ESC))
                  clrBuffer <= 1'b1;
               // After a timeout the same edit mode must be left before it re-arms.
               if (!(lockout && (mode == lock_mode))) begin
                  if (mode_clk) begin
                     state     <= EDIT_CLK;
                     edit_buf  <= '0;
                     digit_cnt <= '0;
                     timer     <= '0;
                  end else if (mode_alm && sel_ok) begin
                     state     <= EDIT_ALM;
                     sel_q     <= alarm_sel;
                     edit_buf  <= alm_slot[alarm_sel];
                     digit_cnt <= '0;
                     timer     <= '0;
                  end
               end
            end
            EDIT_CLK, EDIT_ALM: begin
               if (!mode_match) begin
                  state     <= IDLE;
                  edit_buf  <= '0;
                  digit_cnt <= '0;
                  timer     <= '0;
               end else if (key_valid) begin
                  timer <= '0;
                  if (key_code == KEY_ENTER) begin
                     clrBuffer <= 1'b1;
                     if (entry_ok) begin
                        digit_cnt <= '0;
                        if (state == EDIT_CLK) begin
                           new_time_hhmmss <= edit_buf;
                           ld_timeofdayreg <= 1'b1;
                        end
                     end else begin
                        entry_err <= 1'b1;
                     end
                  end else if (key_code == KEY_ESC) begin
                     edit_buf  <= '0;
                     digit_cnt <= '0;
                     clrBuffer <= 1'b1;
                  end
               end else if (digit_valid) begin
                  timer <= '0;
                  if (digit_ok) begin
                     edit_buf  <= {edit_buf[19:0], digit};
                     digit_cnt <= digit_cnt + 3'd1;
                  end
               end else if (timer == TMR_LAST) begin
                  state     <= IDLE;
                  entry_err <= 1'b1;
                  clrBuffer <= 1'b1;
                  edit_buf  <= '0;
                  digit_cnt <= '0;
                  lockout   <= 1'b1;
                  lock_mode <= mode;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_alarm_time_controller.sv
// Directed bench for multi_alarm_time_controller: table of clock-set entries plus
// hand sequences for alarms, ring/dismiss, toggle, timeout and reset.
module tb_multi_alarm_time_controller;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic [1:0]  alarm_sel;
   logic        key_valid;
   logic [1:0]  key_code;
   logic        digit_valid;
   logic [3:0]  digit;
   logic [23:0] hhmmss;
   logic [23:0] edit_buf;
   logic [2:0]  digit_cnt;
   logic [23:0] new_time_hhmmss;
   logic        ld_timeofdayreg;
   logic [95:0] alarm_times;
   logic [3:0]  alarm_en;
   logic [3:0]  alarm_ring;
   logic        clrBuffer;
   logic        entry_err;

   int checks   = 0;
   int failures = 0;

   multi_alarm_time_controller #(.N_ALARMS(4), .IDX_W(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .mode(mode), .alarm_sel(alarm_sel),
      .key_valid(key_valid), .key_code(key_code), .digit_valid(digit_valid),
      .digit(digit), .hhmmss(hhmmss), .edit_buf(edit_buf), .digit_cnt(digit_cnt),
      .new_time_hhmmss(new_time_hhmmss), .ld_timeofdayreg(ld_timeofdayreg),
      .alarm_times(alarm_times), .alarm_en(alarm_en), .alarm_ring(alarm_ring),
      .clrBuffer(clrBuffer), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] digits;
      logic        accept;
   } clk_vec_t;

   clk_vec_t tbl[8];

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_digit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic press_key(input logic [1:0] k);
      key_valid = 1'b1;
      key_code  = k;
      step();
      key_valid = 1'b0;
   endtask

   task automatic enter6(input logic [23:0] v);
      for (int j = 5; j >= 0; j--) press_digit(v[j*4 +: 4]);
   endtask

   initial begin
      logic [23:0] exp_new;
      int          n;
      bit          seen;

      tbl[0] = '{24'h123456, 1'b1};
      tbl[1] = '{24'h250000, 1'b0};
      tbl[2] = '{24'h236000, 1'b0};
      tbl[3] = '{24'h235959, 1'b1};
      tbl[4] = '{24'h000000, 1'b1};
      tbl[5] = '{24'h120060, 1'b0};
      tbl[6] = '{24'h195900, 1'b1};
      tbl[7] = '{24'h240000, 1'b0};

      reset = 1'b0; mode = 2'b00; alarm_sel = 2'd0; key_valid = 1'b0; key_code = 2'b00;
      digit_valid = 1'b0; digit = 4'd0; hhmmss = 24'h0;
      #1;
      chk("rst_edit_buf", edit_buf, 24'h0);
      chk("rst_alarm_times", alarm_times, 96'h0);
      chk("rst_strobes", {ld_timeofdayreg, clrBuffer, entry_err, alarm_en, alarm_ring}, 11'h0);
      step(); step();
      reset = 1'b1;
      step();

      // Clock-set table
      mode = 2'b01;
      step();
      exp_new = 24'h0;
      for (int r = 0; r < 8; r++) begin
         press_key(2'b10);
         enter6(tbl[r].digits);
         chk("tbl_buf_before_enter", edit_buf, tbl[r].digits);
         chk("tbl_cnt_before_enter", digit_cnt, 3'd6);
         press_key(2'b01);
         if (tbl[r].accept) exp_new = tbl[r].digits;
         chk("tbl_ld", ld_timeofdayreg, tbl[r].accept);
         chk("tbl_err", entry_err, !tbl[r].accept);
         chk("tbl_clr", clrBuffer, 1'b1);
         chk("tbl_cnt_after", digit_cnt, tbl[r].accept ? 3'd0 : 3'd6);
         chk("tbl_buf_after", edit_buf, tbl[r].digits);
         chk("tbl_new_time", new_time_hhmmss, exp_new);
         step();
         chk("tbl_strobes_drop", {ld_timeofdayreg, entry_err, clrBuffer}, 3'b000);
      end

      press_key(2'b10);
      chk("esc_buf", edit_buf, 24'h0);
      chk("esc_cnt", digit_cnt, 3'd0);
      chk("esc_clr", clrBuffer, 1'b1);

      // Alarm set, ring and dismiss
      mode = 2'b00;
      step();
      chk("exit_buf", edit_buf, 24'h0);
      mode = 2'b10; alarm_sel = 2'd2;
      step();
      enter6(24'h070000);
      press_key(2'b01);
      chk("alm_times", alarm_times, {24'h0, 24'h070000, 24'h0, 24'h0});
      chk("alm_en", alarm_en, 4'b0100);
      chk("alm_clr_noload", {clrBuffer, ld_timeofdayreg, entry_err}, 3'b100);
      chk("alm_cnt", digit_cnt, 3'd0);
      hhmmss = 24'h065959;
      step();
      chk("ring_before", alarm_ring, 4'b0000);
      hhmmss = 24'h070000;
      step();
      chk("ring_set", alarm_ring, 4'b0100);
      mode = 2'b00;
      step();
      chk("ring_sticky", alarm_ring, 4'b0100);
      press_key(2'b10);
      chk("dismiss_ring", alarm_ring, 4'b0000);
      chk("dismiss_clr", clrBuffer, 1'b1);
      step();
      chk("no_reset_same_time", alarm_ring, 4'b0000);

      // Toggle-disable on a ringing slot, then re-enable
      hhmmss = 24'h065959;
      step();
      hhmmss = 24'h070000;
      step();
      chk("ring_again", alarm_ring, 4'b0100);
      alarm_sel = 2'd2;
      press_key(2'b11);
      chk("toggle_off_en", alarm_en, 4'b0000);
      chk("toggle_off_ring", alarm_ring, 4'b0000);
      press_key(2'b11);
      chk("toggle_on_en", alarm_en, 4'b0100);

      // Entry timeout
      mode = 2'b10; alarm_sel = 2'd1;
      step();
      press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
      chk("to_cnt3", digit_cnt, 3'd3);
      n = 0; seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         step();
         n++;
         if (entry_err) seen = 1;
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_err_clr", {entry_err, clrBuffer}, 2'b11);
      chk("timeout_buf", edit_buf, 24'h0);
      chk("timeout_cnt", digit_cnt, 3'd0);
      chk("timeout_slots", alarm_times, {24'h0, 24'h070000, 24'h0, 24'h0});
      chk("timeout_en", alarm_en, 4'b0100);
      step();
      press_digit(4'd5);
      chk("lockout_idle", {edit_buf, digit_cnt}, 27'h0);
      mode = 2'b00;
      step();
      mode = 2'b10; alarm_sel = 2'd2;
      step();
      chk("reentry_load_slot", edit_buf, 24'h070000);

      // Digit/key collision, digit filters, commit-vs-ring
      press_digit(4'd1); press_digit(4'd2);
      chk("shift_buf", edit_buf, 24'h000012);
      key_valid = 1'b1; key_code = 2'b10; digit_valid = 1'b1; digit = 4'd9;
      step();
      key_valid = 1'b0; digit_valid = 1'b0;
      chk("collide_cnt", digit_cnt, 3'd0);
      chk("collide_buf", edit_buf, 24'h0);
      press_digit(4'hA);
      chk("bad_digit_cnt", digit_cnt, 3'd0);
      enter6(24'h083015);
      press_digit(4'd9);
      chk("seventh_buf", edit_buf, 24'h083015);
      chk("seventh_cnt", digit_cnt, 3'd6);
      hhmmss = 24'h065959;
      step();
      hhmmss = 24'h070000;
      press_key(2'b01);
      chk("commit_slot", alarm_times, {24'h0, 24'h083015, 24'h0, 24'h0});
      chk("commit_beats_ring", alarm_ring, 4'b0000);
      chk("commit_en", alarm_en, 4'b0100);

      // Alarm -> clock mode switch abandons the edit
      press_digit(4'd1); press_digit(4'd2);
      mode = 2'b01;
      step();
      chk("switch_buf", {edit_buf, digit_cnt}, 27'h0);
      chk("switch_no_commit", alarm_times, {24'h0, 24'h083015, 24'h0, 24'h0});
      step();
      press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
      chk("clk_reentry_buf", edit_buf, 24'h001234);
      chk("clk_reentry_cnt", digit_cnt, 3'd4);

      // Async reset mid-edit
      #2 reset = 1'b0;
      #1;
      chk("arst_buf_cnt", {edit_buf, digit_cnt, new_time_hhmmss}, 51'h0);
      chk("arst_alarms", alarm_times, 96'h0);
      chk("arst_flags", {alarm_en, alarm_ring, ld_timeofdayreg, clrBuffer, entry_err}, 11'h0);
      mode = 2'b00;
      #3 reset = 1'b1;
      step();
      press_digit(4'd7);
      chk("post_rst_idle", digit_cnt, 3'd0);
      chk("post_rst_slots", {alarm_times, alarm_en}, 100'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_alarm_time_controller.md
Name: multi_alarm_time_controller

Overview:
- Parametrised successor to the single-alarm time/alarm controller.
- Collects BCD digit entry into an edit buffer, validates it, and commits it to either the time-of-day register or one of N_ALARMS internally held alarm slots.
- Each slot has its own enable and ring flag.
- Adds an entry timeout and range checking. Sits between the keypad decoder and the time-of-day counter/display.

Parameters:
- N_ALARMS, 4, number of alarm slots (1..8).
- IDX_W, 2, width of alarm_sel; must satisfy 2**IDX_W >= N_ALARMS.
- TIMEOUT_CYCLES, 1000, idle cycles in EDIT before automatic abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  00 display, 01 set clock, 10 set alarm, 11 treated as display.
- alarm_sel  in  IDX_W  target slot for set-alarm and toggle; values >= N_ALARMS are ignored.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  2  01 ENTER, 10 ESC, 11 TOGGLE, 00 no-op.
- digit_valid  in  1  one-cycle strobe qualifying digit.
- digit  in  4  BCD digit 0..9; values >9 are ignored.
- hhmmss  in  24  current time, packed BCD {hh,mm,ss}.
- edit_buf  out  24  digits entered so far (display source while editing).
- digit_cnt  out  3  number of digits entered, 0..6.
- new_time_hhmmss  out  24  value to load into the time-of-day register.
- ld_timeofdayreg  out  1  one-cycle load strobe.
- alarm_times  out  24*N_ALARMS  slot i at bits [24i+23:24i].
- alarm_en  out  N_ALARMS  per-slot enable.
- alarm_ring  out  N_ALARMS  per-slot ringing flag.
- clrBuffer  out  1  one-cycle pulse; asks the keypad decoder to flush.
- entry_err  out  1  one-cycle pulse on a rejected ENTER or on timeout.

Behaviour:
- Reset (reset=0, async): all outputs 0, all slots 0, state IDLE, timer 0, prev_time 0.
- States: IDLE, EDIT_CLK, EDIT_ALM.
- All strobes (ld_timeofdayreg, clrBuffer, entry_err) are registered and default to 0 each cycle.
- IDLE:
  - mode=01 -> EDIT_CLK; edit_buf=0, digit_cnt=0.
  - mode=10 with a valid alarm_sel -> EDIT_ALM; the slot index is latched on entry and edit_buf is loaded with alarm_times[sel].
  - Any transition into an EDIT state resets digit_cnt to 0 and the timer to 0.
- Digit entry (EDIT states):
  - On digit_valid with digit<=9 and digit_cnt<6: edit_buf <= {edit_buf[19:0],digit}; digit_cnt++.
  - A 7th digit is ignored.
  - If key_valid and digit_valid are high in the same cycle, the key is processed and the digit is dropped.
- ENTER in EDIT:
  - Accepted only if digit_cnt==6, hh<=23, mm<=59 and ss<=59 (BCD fields; each nibble <=9 is guaranteed by entry).
  - EDIT_CLK accept: new_time_hhmmss<=edit_buf; ld_timeofdayreg=1.
  - EDIT_ALM accept: the latched slot <= edit_buf, and that slot's alarm_en is set to 1.
  - Every accept: clrBuffer=1, digit_cnt=0, stay in the state.
  - Reject: entry_err=1, clrBuffer=1, edit_buf and digit_cnt unchanged.
- ESC in EDIT: edit_buf=0, digit_cnt=0, clrBuffer=1.
- Timer in EDIT:
  - Increments every cycle with no key_valid and no digit_valid; either strobe clears it.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, entry_err=1, clrBuffer=1, edit_buf=0, digit_cnt=0. The block then stays in IDLE until mode leaves and re-enters 01/10.
- Mode change in EDIT:
  - mode differing from the state's mode (including switching clock<->alarm) -> IDLE next cycle; edit_buf=0, nothing is committed.
  - Re-entry happens from IDLE on the following cycle.
- alarm_sel changes while in EDIT_ALM have no effect until the next entry.
- TOGGLE, valid in IDLE or EDIT_ALM: alarm_en[alarm_sel] ^= 1. Disabling a slot also clears its ring.
- Ring detection:
  - prev_time <= hhmmss every cycle.
  - For each i: if alarm_en[i] and hhmmss==alarm_times[i] and hhmmss!=prev_time, then alarm_ring[i]<=1.
  - Ring is evaluated in every state, including while editing.
- Dismiss: ESC in IDLE clears all alarm_ring bits and pulses clrBuffer.
- Same-cycle conflicts:
  - Ring set on the same slot as a commit: the commit wins; ring stays 0 that cycle.
  - Ring set on the same slot as a TOGGLE-disable: the disable wins.
- No arithmetic beyond the compares; the timer is $clog2(TIMEOUT_CYCLES) bits wide and saturates at abort.

Test Plan:
- Reset=0 mid-EDIT with digit_cnt=4 -> all outputs 0 asynchronously; after release the block is in IDLE with slots cleared.
- mode=01, digits 1,2,3,4,5,6, ENTER -> ld_timeofdayreg pulses 1 cycle with new_time_hhmmss=24'h123456; clrBuffer pulses; digit_cnt=0.
- mode=01, digits 2,5,0,0,0,0, ENTER -> entry_err pulses, no load, edit_buf stays 24'h250000. Then ESC -> edit_buf=0.
- mode=10, alarm_sel=2, enter 070000, ENTER -> alarm_times[2]=24'h070000 and alarm_en[2]=1. Drive hhmmss from 065959 to 070000 -> alarm_ring[2]=1 next cycle. mode=00, ESC -> ring cleared.
- mode=10, enter 3 digits, then idle for TIMEOUT_CYCLES cycles -> entry_err and clrBuffer pulse, state IDLE, edit_buf=0, no slot changed.
- In IDLE, TOGGLE on slot 2 while it is ringing -> alarm_en[2]=0 and alarm_ring[2]=0. Same-cycle digit_valid and key_valid(ESC) in EDIT -> the digit is dropped and digit_cnt=0.
